register_mode_cfg: RTL and testbench
====================================

# register_mode_cfg

Configuration front-end for the register-mode tile. It sits directly upstream of the mode register and drives its `mode`, `const_`, `config_we`, `config_data` and `clk_en` inputs from a valid/ready configuration bus. The bus provides addressed writes and reads, a one-cycle write pulse into the data register, and a counted single-step clock enable. Reads return the stored configuration or the live register value fed back from the tile.

## Interface
Parameters:
- `width`, 4, data width of `const_`, data register and bus data; legal range 3..32.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - `CLK`  in  1  clock, all state updates on rising edge.
  - `ASYNCRESET`  in  1  asynchronous active-high reset.
- Configuration request channel:
  - `cfg_valid`  in  1  request valid.
  - `cfg_ready`  out  1  request accepted on an edge where valid and ready are both 1.
  - `cfg_write`  in  1  1 = write, 0 = read.
  - `cfg_addr`  in  2  register select.
  - `cfg_wdata`  in  width  write data.
- Read response channel:
  - `rsp_valid`  out  1  read response valid.
  - `rsp_ready`  in  1  response consumed on an edge where valid and ready are both 1.
  - `rsp_data`  out  width  read data.
- Tile-facing outputs and feedback:
  - `reg_value`  in  width  current data-register value fed back from the tile.
  - `mode`  out  2  tile mode.
  - `const_`  out  width  tile constant.
  - `config_we`  out  1  data-register load strobe.
  - `config_data`  out  width  data-register load value.
  - `clk_en`  out  1  tile clock enable.

## Operation
- Address map:
  - 0: mode. Writes store `wdata[1:0]` and ignore the upper bits. Reads return the mode zero-extended. All four codes are stored unmodified, including 2'h3.
  - 1: const_. Full width, read/write.
  - 2: data. A write launches the config_we pulse. A read returns `reg_value` as sampled on the accept edge.
  - 3: enable. bit0 = `hold`; bits [width-1:1] = `step` count. A read returns `{remaining step count, hold}`.
- `clk_en = hold | (step_cnt != 0)`, registered.
- `step_cnt` behaviour:
  - Loaded by an address-3 write.
  - Decrements by 1 on every edge while nonzero.
  - Saturates at 0 and never wraps.
  - Maximum count is 2^(width-1)-1 (7 for width 4).
- FSM states: IDLE, PULSE, RESP.
  - IDLE: `cfg_ready=1`.
    - Write to addr 0, 1 or 3 is applied on the accept edge; FSM stays in IDLE.
    - Write to addr 2 moves to PULSE.
    - Any read moves to RESP.
  - PULSE: `cfg_ready=0`, `config_we=1`, `config_data` = accepted wdata. Returns to IDLE after exactly one cycle.
  - RESP: `cfg_ready=0`, `rsp_valid=1`, `rsp_data` held stable. Moves to IDLE on the edge where `rsp_ready=1`.
- Writes produce no response. Exactly one response is produced per read.
- `config_data` retains its last value outside PULSE. `config_we` is 0 outside PULSE.
- Reset values: `mode=0`, `const_=0`, `config_we=0`, `config_data=0`, `clk_en=0`, `hold=0`, `step_cnt=0`, `rsp_valid=0`, `rsp_data=0`, FSM=IDLE (so `cfg_ready=1` during and after reset).

## Timing
- Write to addr 0/1/3 accepted at edge k: the new value is visible on `mode`/`const_`/`clk_en` from edge k onward (1-cycle latency from request).
- Write to addr 2 accepted at edge k:
  - `config_we=1` between edges k and k+1.
  - The tile register loads at edge k+1.
  - `cfg_ready` returns to 1 after edge k+1.
  - Back-to-back addr-2 writes are therefore at most one every 2 cycles.
- Read accepted at edge k: `rsp_valid=1` and `rsp_data` valid from edge k. This is 1-cycle latency, and the sample is taken on edge k.
- RESP with `rsp_ready` held 1 lasts exactly 1 cycle. With `rsp_ready=0` the response is held indefinitely, with no data change.
- Step count:
  - An addr-3 write of step=n, hold=0 at edge k gives `clk_en=1` for exactly n cycles (edges k..k+n-1 registered), then 0.
  - n=0 with hold=0 forces `clk_en=0` from edge k.
- Simultaneous events: an addr-3 write on the same edge that the counter would decrement or reach 0 takes priority and loads the new count.
- Reading addr 3 while counting returns the count before that edge's decrement.
- Reset asserted mid-operation:
  - Any pending PULSE is dropped (no `config_we`).
  - Any pending response is discarded.
  - The counter is cleared.
  - All outputs take their reset values asynchronously.
- `cfg_valid` sampled while `cfg_ready=0` is ignored. The requester holds the request until it is accepted.

## Test plan
- Reset, then write addr0=2'h1, addr1=4'hA → `mode=1`, `const_=A` one cycle after acceptance. Read addr1 → `rsp_data=4'hA`, 1-cycle latency.
- Write addr2=4'h5 → `config_we` high exactly 1 cycle with `config_data=5`. `cfg_ready` low that cycle. A second addr-2 write issued immediately is accepted only after the pulse.
- Write addr3 with step=3, hold=0 → `clk_en` high exactly 3 cycles. Read addr3 mid-count returns the decremented count. Rewrite step=7 at the final count cycle → 7 more cycles, no gap.
- Read addr2 with `reg_value=4'hC` and `rsp_ready` held 0 for 4 cycles → `rsp_valid` and `rsp_data=C` stable. `cfg_ready=0` until the handshake completes.
- Assert `ASYNCRESET` during PULSE and during RESP → `config_we`, `rsp_valid` and `clk_en` drop immediately. FSM restarts in IDLE with all registers zero.
- Write addr0 with wdata=4'hF → stored mode=3. Read addr0 returns 4'h3 (upper bits zero).

Source files
------------

// File: rtl/register_mode_cfg.sv
// ---------------------------------------------------------------------------
// register_mode_cfg
//
// Configuration front-end for the register-mode tile. Drives the tile's mode,
// constant, data-register load strobe and clock enable from a valid/ready
// configuration bus. Reads return the stored configuration, or the live
// data-register value fed back from the tile.
//
// Parameters:
//   width        data width of const_, data register and bus data (3..32)
//
// Ports:
//   CLK          clock, all state updates on rising edge
//   ASYNCRESET   asynchronous active-high reset
//   cfg_valid    request valid
//   cfg_ready    request accepted when cfg_valid & cfg_ready on an edge
//   cfg_write    1 = write, 0 = read
//   cfg_addr     register select (0 mode, 1 const_, 2 data, 3 enable)
//   cfg_wdata    write data
//   rsp_valid    read response valid
//   rsp_ready    response consumed when rsp_valid & rsp_ready on an edge
//   rsp_data     read data
//   reg_value    current tile data-register value
//   mode         tile mode
//   const_       tile constant
//   config_we    one-cycle data-register load strobe
//   config_data  data-register load value
//   clk_en       tile clock enable (hold, or counted single-step)
// ---------------------------------------------------------------------------
module register_mode_cfg #(
   parameter int width = 4
) (
   input  logic             CLK,
   input  logic             ASYNCRESET,
   // configuration request channel
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic             cfg_write,
   input  logic [1:0]       cfg_addr,
   input  logic [width-1:0] cfg_wdata,
   // read response channel
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [width-1:0] rsp_data,
   // tile-facing outputs and feedback
   input  logic [width-1:0] reg_value,
   output logic [1:0]       mode,
   output logic [width-1:0] const_,
   output logic             config_we,
   output logic [width-1:0] config_data,
   output logic             clk_en
);

   localparam logic [1:0] ADDR_MODE   = 2'd0;
   localparam logic [1:0] ADDR_CONST  = 2'd1;
   localparam logic [1:0] ADDR_DATA   = 2'd2;
   localparam logic [1:0] ADDR_ENABLE = 2'd3;

   localparam logic [width-2:0] STEP_ONE = {{(width-2){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t           state_q;
   logic             cfg_ready_q;
   logic             rsp_valid_q;
   logic [width-1:0] rsp_data_q;
   logic [1:0]       mode_q;
   logic [width-1:0] const_q;
   logic             config_we_q;
   logic [width-1:0] config_data_q;
   logic             clk_en_q;
   logic             hold_q;
   logic [width-2:0] step_cnt_q;

   logic             hold_d;
   logic [width-2:0] step_cnt_d;
   logic [width-1:0] rd_mux;
   logic             accept;

   // cfg_ready_q is high exactly while the FSM sits in IDLE.
   assign accept = cfg_valid & cfg_ready_q;

   // Enable register next state. A write to the enable register wins over the
   // free-running decrement, so a reload on the last count cycle leaves no gap.
   always_comb begin
      hold_d     = hold_q;
      step_cnt_d = step_cnt_q;
      if (accept && cfg_write && (cfg_addr == ADDR_ENABLE)) begin
         hold_d     = cfg_wdata[0];
         step_cnt_d = cfg_wdata[width-1:1];
      end else if (step_cnt_q != '0) begin
         step_cnt_d = step_cnt_q - STEP_ONE;
      end
   end

   // Read data is taken from the pre-edge register contents, so an enable read
   // reports the count before this edge's decrement.
   always_comb begin
      rd_mux = '0;
      case (cfg_addr)
         ADDR_MODE:   rd_mux = {{(width-2){1'b0}}, mode_q};
         ADDR_CONST:  rd_mux = const_q;
         ADDR_DATA:   rd_mux = reg_value;
         ADDR_ENABLE: rd_mux = {step_cnt_q, hold_q};
         default:     rd_mux = '0;
      endcase
   end

   always_ff @(posedge CLK or posedge ASYNCRESET) begin
      if (ASYNCRESET) begin
         state_q       <= IDLE;
         cfg_ready_q   <= 1'b1;
         rsp_valid_q   <= 1'b0;
         rsp_data_q    <= '0;
         mode_q        <= 2'd0;
         const_q       <= '0;
         config_we_q   <= 1'b0;
         config_data_q <= '0;
         clk_en_q      <= 1'b0;
         hold_q        <= 1'b0;
         step_cnt_q    <= '0;
      end else begin
         hold_q     <= hold_d;
         step_cnt_q <= step_cnt_d;
         // Registered from next-state values so a write is visible right
         // after its accept edge.
         clk_en_q   <= hold_d | (step_cnt_d != '0);

         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (cfg_write) begin
                     case (cfg_addr)
                        ADDR_MODE:  mode_q  <= cfg_wdata[1:0];
                        ADDR_CONST: const_q <= cfg_wdata;
                        ADDR_DATA: begin
                           config_we_q   <= 1'b1;
                           config_data_q <= cfg_wdata;
                           cfg_ready_q   <= 1'b0;
                           state_q       <= PULSE;
                        end
                        default: ; // enable register handled above
                     endcase
                  end else begin
                     rsp_data_q  <= rd_mux;
                     rsp_valid_q <= 1'b1;
                     cfg_ready_q <= 1'b0;
                     state_q     <= RESP;
                  end
               end
            end
            PULSE: begin
               // Single-cycle strobe; config_data keeps its value afterwards.
               config_we_q <= 1'b0;
               cfg_ready_q <= 1'b1;
               state_q     <= IDLE;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  cfg_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               config_we_q <= 1'b0;
               rsp_valid_q <= 1'b0;
               cfg_ready_q <= 1'b1;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign cfg_ready   = cfg_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = rsp_data_q;
   assign mode        = mode_q;
   assign const_      = const_q;
   assign config_we   = config_we_q;
   assign config_data = config_data_q;
   assign clk_en      = clk_en_q;

endmodule

// File: tb/tb_register_mode_cfg.sv
// ---------------------------------------------------------------------------
// tb_register_mode_cfg
//
// Directed vector table for the documented scenarios, hand-written reset
// sequences, then randomized traffic checked against a behavioural model.
// ---------------------------------------------------------------------------
module tb_register_mode_cfg;

   localparam int W = 4;

   logic         CLK = 1'b0;
   logic         ASYNCRESET;
   logic         cfg_valid;
   logic         cfg_ready;
   logic         cfg_write;
   logic [1:0]   cfg_addr;
   logic [W-1:0] cfg_wdata;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_data;
   logic [W-1:0] reg_value;
   logic [1:0]   mode;
   logic [W-1:0] const_;
   logic         config_we;
   logic [W-1:0] config_data;
   logic         clk_en;

   register_mode_cfg #(.width(W)) dut (
      .CLK         (CLK),
      .ASYNCRESET  (ASYNCRESET),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_write   (cfg_write),
      .cfg_addr    (cfg_addr),
      .cfg_wdata   (cfg_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .reg_value   (reg_value),
      .mode        (mode),
      .const_      (const_),
      .config_we   (config_we),
      .config_data (config_data),
      .clk_en      (clk_en)
   );

   always #5 CLK = ~CLK;

   int vectors     = 0;
   int miscompares = 0;

   // ---------------- behavioural reference model ----------------
   int           m_mode;
   logic [W-1:0] m_const;
   logic [W-1:0] m_cdata;
   logic [W-1:0] m_rsp_data;
   bit           m_hold;
   int           m_steps;
   bit           m_pulse;   // a load strobe is showing this cycle
   bit           m_resp;    // a read response is outstanding

   function automatic bit m_ready();
      return !m_pulse && !m_resp;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_const = '0; m_cdata = '0; m_rsp_data = '0;
      m_hold = 0; m_steps = 0; m_pulse = 0; m_resp = 0;
   endtask

   // Advance the model by one rising edge using the currently driven inputs.
   task automatic model_edge();
      bit rdy;
      int steps_after;
      bit resp_after;
      bit pulse_after;
      rdy         = m_ready();
      steps_after = (m_steps > 0) ? m_steps - 1 : 0;
      resp_after  = m_resp && !rsp_ready;
      pulse_after = 0;
      if (cfg_valid && rdy) begin
         if (cfg_write) begin
            case (int'(cfg_addr))
               0: m_mode  = int'(cfg_wdata) % 4;
               1: m_const = cfg_wdata;
               2: begin pulse_after = 1; m_cdata = cfg_wdata; end
               default: begin m_hold = cfg_wdata[0]; steps_after = int'(cfg_wdata) / 2; end
            endcase
         end else begin
            resp_after = 1;
            case (int'(cfg_addr))
               0: m_rsp_data = W'(m_mode);
               1: m_rsp_data = m_const;
               2: m_rsp_data = reg_value;
               default: m_rsp_data = W'(m_steps * 2 + int'(m_hold));
            endcase
         end
      end
      m_steps = steps_after;
      m_resp  = resp_after;
      m_pulse = pulse_after;
   endtask

   task automatic tick();
      model_edge();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string name,
                        input logic e_rdy, input logic e_rv, input logic [W-1:0] e_rd,
                        input logic [1:0] e_mode, input logic [W-1:0] e_const,
                        input logic e_we, input logic [W-1:0] e_cd, input logic e_ce);
      vectors++;
      if ({cfg_ready, rsp_valid, rsp_data, mode, const_, config_we, config_data, clk_en} !==
          {e_rdy, e_rv, e_rd, e_mode, e_const, e_we, e_cd, e_ce}) begin
         miscompares++;
         $display("FAIL %s: got rdy=%b rv=%b rd=%h mode=%h const=%h we=%b cd=%h ce=%b, required rdy=%b rv=%b rd=%h mode=%h const=%h we=%b cd=%h ce=%b",
                  name, cfg_ready, rsp_valid, rsp_data, mode, const_, config_we, config_data, clk_en,
                  e_rdy, e_rv, e_rd, e_mode, e_const, e_we, e_cd, e_ce);
      end
   endtask

   task automatic check_model(input string name);
      check(name, m_ready(), m_resp, m_rsp_data, 2'(m_mode), m_const, m_pulse, m_cdata,
            m_hold || (m_steps != 0));
   endtask

   task automatic drive(input logic v, input logic w, input logic [1:0] a,
                        input logic [W-1:0] wd, input logic rr, input logic [W-1:0] rv);
      cfg_valid = v; cfg_write = w; cfg_addr = a; cfg_wdata = wd;
      rsp_ready = rr; reg_value = rv;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic         v, w;
      logic [1:0]   a;
      logic [W-1:0] wd;
      logic         rr;
      logic [W-1:0] regv;
      logic         e_rdy, e_rv;
      logic [W-1:0] e_rd;
      logic [1:0]   e_mode;
      logic [W-1:0] e_const;
      logic         e_we;
      logic [W-1:0] e_cd;
      logic         e_ce;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic v, input logic w, input logic [1:0] a, input logic [W-1:0] wd,
                      input logic rr, input logic [W-1:0] regv,
                      input logic e_rdy, input logic e_rv, input logic [W-1:0] e_rd,
                      input logic [1:0] e_mode, input logic [W-1:0] e_const,
                      input logic e_we, input logic [W-1:0] e_cd, input logic e_ce);
      vec_t t;
      t.v = v; t.w = w; t.a = a; t.wd = wd; t.rr = rr; t.regv = regv;
      t.e_rdy = e_rdy; t.e_rv = e_rv; t.e_rd = e_rd; t.e_mode = e_mode;
      t.e_const = e_const; t.e_we = e_we; t.e_cd = e_cd; t.e_ce = e_ce;
      tbl.push_back(t);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //  v w a  wd    rr regv   rdy rv rd    mode const we cd    ce
      add(0,0,0,4'h0, 1,4'h0,  1,0,4'h0, 0,4'h0, 0,4'h0, 0); // idle after reset
      add(1,1,0,4'h1, 1,4'h0,  1,0,4'h0, 1,4'h0, 0,4'h0, 0); // mode=1
      add(1,1,1,4'hA, 1,4'h0,  1,0,4'h0, 1,4'hA, 0,4'h0, 0); // const=A
      add(1,0,1,4'h0, 1,4'h0,  0,1,4'hA, 1,4'hA, 0,4'h0, 0); // read const
      add(0,0,0,4'h0, 1,4'h0,  1,0,4'hA, 1,4'hA, 0,4'h0, 0); // response consumed
      add(1,1,2,4'h5, 1,4'h0,  0,0,4'hA, 1,4'hA, 1,4'h5, 0); // pulse data=5
      add(1,1,2,4'h6, 1,4'h0,  1,0,4'hA, 1,4'hA, 0,4'h5, 0); // 2nd write ignored
      add(1,1,2,4'h6, 1,4'h0,  0,0,4'hA, 1,4'hA, 1,4'h6, 0); // now accepted
      add(0,0,0,4'h0, 1,4'h0,  1,0,4'hA, 1,4'hA, 0,4'h6, 0);
      add(1,1,3,4'h6, 1,4'h0,  1,0,4'hA, 1,4'hA, 0,4'h6, 1); // step=3
      add(0,0,0,4'h0, 1,4'h0,  1,0,4'hA, 1,4'hA, 0,4'h6, 1);
      add(1,0,3,4'h0, 1,4'h0,  0,1,4'h4, 1,4'hA, 0,4'h6, 1); // read {2,0}
      add(0,0,0,4'h0, 1,4'h0,  1,0,4'h4, 1,4'hA, 0,4'h6, 0); // 3 cycles done
      add(1,1,3,4'h6, 1,4'h0,  1,0,4'h4, 1,4'hA, 0,4'h6, 1); // step=3 again
      add(0,0,0,4'h0, 1,4'h0,  1,0,4'h4, 1,4'hA, 0,4'h6, 1);
      add(0,0,0,4'h0, 1,4'h0,  1,0,4'h4, 1,4'hA, 0,4'h6, 1);
      add(1,1,3,4'hE, 1,4'h0,  1,0,4'h4, 1,4'hA, 0,4'h6, 1); // reload 7 on last
      for (int i = 0; i < 6; i++)
         add(0,0,0,4'h0, 1,4'h0, 1,0,4'h4, 1,4'hA, 0,4'h6, 1);
      add(0,0,0,4'h0, 1,4'h0,  1,0,4'h4, 1,4'hA, 0,4'h6, 0); // 7 cycles done
      add(1,0,2,4'h0, 0,4'hC,  0,1,4'hC, 1,4'hA, 0,4'h6, 0); // read data reg
      for (int i = 0; i < 3; i++)
         add(0,0,0,4'h0, 0,4'h3, 0,1,4'hC, 1,4'hA, 0,4'h6, 0); // held stable
      add(0,0,0,4'h0, 1,4'h3,  1,0,4'hC, 1,4'hA, 0,4'h6, 0); // handshake
      add(1,1,0,4'hF, 1,4'h0,  1,0,4'hC, 3,4'hA, 0,4'h6, 0); // mode=3
      add(1,0,0,4'h0, 1,4'h0,  0,1,4'h3, 3,4'hA, 0,4'h6, 0); // read mode
      add(0,0,0,4'h0, 1,4'h0,  1,0,4'h3, 3,4'hA, 0,4'h6, 0);
      add(1,1,3,4'h1, 1,4'h0,  1,0,4'h3, 3,4'hA, 0,4'h6, 1); // hold=1
      add(0,0,0,4'h0, 1,4'h0,  1,0,4'h3, 3,4'hA, 0,4'h6, 1);
      add(1,0,3,4'h0, 1,4'h0,  0,1,4'h1, 3,4'hA, 0,4'h6, 1); // read {0,1}
      add(0,0,0,4'h0, 1,4'h0,  1,0,4'h1, 3,4'hA, 0,4'h6, 1);
      add(1,1,3,4'h0, 1,4'h0,  1,0,4'h1, 3,4'hA, 0,4'h6, 0); // hold off
      add(1,1,3,4'hA, 1,4'h0,  1,0,4'h1, 3,4'hA, 0,4'h6, 1); // step=5
      add(1,1,3,4'h0, 1,4'h0,  1,0,4'h1, 3,4'hA, 0,4'h6, 0); // n=0 stops now

      // Reset state, checked while reset is still asserted.
      model_reset();
      drive(0, 0, 2'd0, '0, 1'b1, '0);
      ASYNCRESET = 1'b1;
      #2;
      check("reset_state", 1, 0, 4'h0, 0, 4'h0, 0, 4'h0, 0);
      @(negedge CLK);
      ASYNCRESET = 1'b0;

      foreach (tbl[i]) begin
         drive(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].rr, tbl[i].regv);
         $display("vec %0d: v=%b w=%b addr=%0d wdata=%h rsp_ready=%b reg_value=%h",
                  i, tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].rr, tbl[i].regv);
         tick();
         check($sformatf("table[%0d]", i), tbl[i].e_rdy, tbl[i].e_rv, tbl[i].e_rd,
               tbl[i].e_mode, tbl[i].e_const, tbl[i].e_we, tbl[i].e_cd, tbl[i].e_ce);
      end

      // Reset during a load pulse: strobe must vanish immediately.
      drive(1, 1, 2'd2, 4'h9, 1'b1, '0);
      $display("seq reset_in_pulse: write addr=2 data=9");
      tick();
      check_model("pulse_before_reset");
      drive(0, 0, 2'd0, '0, 1'b1, '0);
      #2;
      ASYNCRESET = 1'b1;
      #1;
      model_reset();
      check("reset_in_pulse", 1, 0, 4'h0, 0, 4'h0, 0, 4'h0, 0);
      @(negedge CLK);
      ASYNCRESET = 1'b0;

      // Reset during an unconsumed response with the clock enable active.
      drive(1, 1, 2'd3, 4'hF, 1'b1, '0);
      $display("seq reset_in_resp: write addr=3 data=f, then read addr=1");
      tick();
      drive(1, 0, 2'd1, '0, 1'b0, '0);
      tick();
      check_model("resp_before_reset");
      drive(0, 0, 2'd0, '0, 1'b0, '0);
      #2;
      ASYNCRESET = 1'b1;
      #1;
      model_reset();
      check("reset_in_resp", 1, 0, 4'h0, 0, 4'h0, 0, 4'h0, 0);
      @(negedge CLK);
      ASYNCRESET = 1'b0;
      drive(0, 0, 2'd0, '0, 1'b1, '0);
      tick();
      check_model("idle_after_reset");

      // Randomized traffic; a request is held until the model says accepted.
      for (int i = 0; i < 1500; i++) begin
         if (m_ready()) begin
            cfg_valid = ($urandom_range(0, 3) != 0);
            cfg_write = 1'($urandom_range(0, 1));
            cfg_addr  = 2'($urandom_range(0, 3));
            cfg_wdata = W'($urandom);
         end
         rsp_ready = ($urandom_range(0, 2) != 0);
         reg_value = W'($urandom);
         if (cfg_valid && m_ready())
            $display("txn %0d: %s addr=%0d wdata=%h reg_value=%h",
                     i, cfg_write ? "wr" : "rd", cfg_addr, cfg_wdata, reg_value);
         tick();
         check_model($sformatf("rand[%0d]", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
